// File: rtl/multiplicity_trigger_pkg.sv
// Shared types and constants for the large-PMT multiplicity trigger.
// Latency: n/a (package). Backpressure: n/a.
package mt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLDOFF = 2'd1,
        REARM   = 2'd2
    } state_t;

    localparam int ADC_WIDTH    = 24;
    localparam int HG_MSB       = 23;
    localparam int HG_LSB       = 12;
    localparam int SAMPLE_WIDTH = 12;
    localparam int NCHAN        = 3;
    localparam int POP_WIDTH    = $clog2(NCHAN + 1);

    // HG minus pedestal, clamped at zero so a low baseline never wraps high.
    function automatic logic [SAMPLE_WIDTH-1:0] ped_sub(
        input logic [SAMPLE_WIDTH-1:0] hg,
        input logic [SAMPLE_WIDTH-1:0] ped
    );
        logic signed [SAMPLE_WIDTH:0] d;
        d = $signed({1'b0, hg}) - $signed({1'b0, ped});
        return d[SAMPLE_WIDTH] ? '0 : d[SAMPLE_WIDTH-1:0];
    endfunction

    function automatic logic [POP_WIDTH-1:0] count_ones(input logic [NCHAN-1:0] v);
        logic [POP_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < NCHAN; i++) begin
            n = n + POP_WIDTH'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/multiplicity_trigger_if.sv
// ADC/config/trigger bundle between the injector side and the trigger stage.
// Latency: n/a (wires only). Backpressure: none, free-running sample stream.
interface multiplicity_trigger_if #(
    parameter int MINW_BITS    = 4,
    parameter int HOLDOFF_BITS = 16,
    parameter int COUNT_BITS   = 32
);
    logic                                ENABLE;
    logic                                CLR_COUNT;
    logic [mt_pkg::ADC_WIDTH-1:0]        ADC0_IN;
    logic [mt_pkg::ADC_WIDTH-1:0]        ADC1_IN;
    logic [mt_pkg::ADC_WIDTH-1:0]        ADC2_IN;
    logic [mt_pkg::SAMPLE_WIDTH-1:0]     PEDESTAL;
    logic [mt_pkg::SAMPLE_WIDTH-1:0]     THRESHOLD;
    logic [1:0]                          MULTIPLICITY;
    logic [MINW_BITS-1:0]                MIN_WIDTH;
    logic [HOLDOFF_BITS-1:0]             HOLDOFF;
    logic                                TRIG;
    logic [mt_pkg::NCHAN-1:0]            TRIG_PATTERN;
    logic [COUNT_BITS-1:0]               TRIG_COUNT;

    modport master (
        output ENABLE, CLR_COUNT, ADC0_IN, ADC1_IN, ADC2_IN,
        output PEDESTAL, THRESHOLD, MULTIPLICITY, MIN_WIDTH, HOLDOFF,
        input  TRIG, TRIG_PATTERN, TRIG_COUNT
    );

    modport slave (
        input  ENABLE, CLR_COUNT, ADC0_IN, ADC1_IN, ADC2_IN,
        input  PEDESTAL, THRESHOLD, MULTIPLICITY, MIN_WIDTH, HOLDOFF,
        output TRIG, TRIG_PATTERN, TRIG_COUNT
    );
endinterface

// File: rtl/multiplicity_trigger_chan_qual.sv
// Per-channel qualifier: pedestal subtract, strict threshold, saturating run-length counter.
// Latency: 2 registers from ADC word to QUAL. Backpressure: none.
module trig_chan_qual
    import mt_pkg::*;
#(
    parameter int MINW_BITS = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [ADC_WIDTH-1:0]    ADC_IN,
    input  logic [SAMPLE_WIDTH-1:0] PEDESTAL,
    input  logic [SAMPLE_WIDTH-1:0] THRESHOLD,
    input  logic [MINW_BITS-1:0]    MIN_WIDTH,
    output logic                    QUAL
);
    localparam logic [MINW_BITS-1:0] CNT_MAX = '1;

    logic [SAMPLE_WIDTH-1:0] diff;
    logic [MINW_BITS-1:0]    cnt;
    logic [MINW_BITS-1:0]    min_eff;
    logic                    over;
    logic                    unused_lg;

    // Low-gain half of the word carries no trigger information.
    assign unused_lg = ^ADC_IN[HG_LSB-1:0];

    always_ff @(posedge CLK) begin
        if (RST) begin
            diff <= '0;
            cnt  <= '0;
        end else begin
            diff <= ped_sub(ADC_IN[HG_MSB:HG_LSB], PEDESTAL);
            if (!over) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        over    = diff > THRESHOLD;
        min_eff = (MIN_WIDTH == '0) ? MINW_BITS'(1) : MIN_WIDTH;
        QUAL    = cnt >= min_eff;
    end

endmodule

// File: rtl/multiplicity_trigger.sv
// Multiplicity trigger: popcount of qualified channels, holdoff/re-arm FSM, trigger counter.
// Latency: TRIG one register after QUAL (MIN_WIDTH+2 edges from first sample). Backpressure: none.
module multiplicity_trigger
    import mt_pkg::*;
#(
    parameter int MINW_BITS    = 4,
    parameter int HOLDOFF_BITS = 16,
    parameter int COUNT_BITS   = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    multiplicity_trigger_if.slave   bus
);
    logic [ADC_WIDTH-1:0]    adc [NCHAN];
    logic [NCHAN-1:0]        qual;
    logic [POP_WIDTH-1:0]    n_qual;
    logic                    hit;

    state_t                  state_q, state_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic                    trig_q, trig_d;
    logic [NCHAN-1:0]        pat_q, pat_d;
    logic [COUNT_BITS-1:0]   cnt_q, cnt_d;

    assign adc[0] = bus.ADC0_IN;
    assign adc[1] = bus.ADC1_IN;
    assign adc[2] = bus.ADC2_IN;

    for (genvar ch = 0; ch < NCHAN; ch++) begin : g_chan
        trig_chan_qual #(
            .MINW_BITS (MINW_BITS)
        ) u_qual (
            .CLK       (CLK),
            .RST       (RST),
            .ADC_IN    (adc[ch]),
            .PEDESTAL  (bus.PEDESTAL),
            .THRESHOLD (bus.THRESHOLD),
            .MIN_WIDTH (bus.MIN_WIDTH),
            .QUAL      (qual[ch])
        );
    end

    always_comb begin
        n_qual = count_ones(qual);
        hit    = (bus.MULTIPLICITY != 2'd0) && (n_qual >= POP_WIDTH'(bus.MULTIPLICITY));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            hold_q  <= '0;
            trig_q  <= 1'b0;
            pat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            trig_q  <= trig_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        trig_d  = 1'b0;
        pat_d   = pat_q;
        cnt_d   = cnt_q;

        if (!bus.ENABLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        trig_d  = 1'b1;
                        pat_d   = qual;
                        cnt_d   = cnt_q + 1'b1;
                        hold_d  = bus.HOLDOFF;
                        state_d = HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_d = REARM;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                // Wait for the pulse that fired us to drop before arming again.
                REARM: begin
                    if (!hit) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (bus.CLR_COUNT) begin
            cnt_d = '0;
        end
    end

    assign bus.TRIG         = trig_q;
    assign bus.TRIG_PATTERN = pat_q;
    assign bus.TRIG_COUNT   = cnt_q;

endmodule

// File: doc/multiplicity_trigger.md
# multiplicity_trigger

Threshold/multiplicity trigger stage directly downstream of the fake-signal injector and upstream of event readout. Takes the three large-PMT ADC words, extracts the high-gain sample, and subtracts a pedestal. It qualifies each channel on a minimum over-threshold width and asserts a one-cycle trigger when enough channels qualify together. A holdoff/re-arm state machine prevents retriggering on the same pulse and keeps a trigger counter.

## Interface
- MINW_BITS, 4: width of MIN_WIDTH and of the per-channel width counters.
- HOLDOFF_BITS, 16: width of HOLDOFF and of the holdoff counter.
- COUNT_BITS, 32: width of TRIG_COUNT.
- CLK  in  1  single clock, 120 MHz, rising edge.
- RST  in  1  reset; synchronous, active-high.
- ENABLE  in  1  trigger enable; pipeline runs regardless.
- CLR_COUNT  in  1  synchronous clear of TRIG_COUNT.
- ADC0_IN, ADC1_IN, ADC2_IN  in  24 each  packed ADC word; HG = [23:12], LG = [11:0]; LG ignored.
- PEDESTAL  in  12  pedestal subtracted from HG, shared by all channels.
- THRESHOLD  in  12  per-channel threshold on pedestal-subtracted HG.
- MULTIPLICITY  in  2  channels required; 0 = never trigger.
- MIN_WIDTH  in  MINW_BITS  consecutive over-threshold samples required; 0 treated as 1.
- HOLDOFF  in  HOLDOFF_BITS  holdoff length in cycles.
- TRIG  out  1  one-cycle trigger pulse.
- TRIG_PATTERN  out  3  qualified channels at last trigger; bit i = ADCi.
- TRIG_COUNT  out  COUNT_BITS  triggers since reset/clear.

## Operation
- Stage 1, per channel: DIFF <= max(HG − PEDESTAL, 0), 12-bit unsigned. Uses a 13-bit signed intermediate and clamps negative results to 0.
- Stage 2, per channel:
  - OVER = DIFF > THRESHOLD, strictly greater.
  - CNT <= OVER ? min(CNT+1, 2^MINW_BITS−1) : 0.
  - QUAL = CNT ≥ max(MIN_WIDTH,1); QUAL is combinational from registered CNT.
- HIT = popcount(QUAL) ≥ MULTIPLICITY and MULTIPLICITY ≠ 0.
- FSM states and transitions:
  - IDLE: if ENABLE and HIT, then TRIG<=1, TRIG_PATTERN<=QUAL, TRIG_COUNT<=TRIG_COUNT+1, HOLD_CNT<=HOLDOFF, go to HOLDOFF.
  - HOLDOFF: if HOLD_CNT==0 go to REARM, else HOLD_CNT−1.
  - REARM: go to IDLE once HIT is false. A pulse that stays above threshold triggers only once.
- TRIG is high only in the cycle after the IDLE trigger decision.
- ENABLE low forces the FSM to IDLE and TRIG to 0. Pipeline and width counters keep running. TRIG_PATTERN and TRIG_COUNT hold their values.
- Config inputs are sampled live. HOLDOFF is captured only at trigger time, so a change during holdoff affects the next trigger only.
- TRIG_COUNT wraps from 2^COUNT_BITS−1 to 0.
- If CLR_COUNT and a trigger occur in the same cycle, clear wins: TRIG_COUNT=0, and TRIG and TRIG_PATTERN still update.
- RST, including mid-holdoff:
  - State becomes IDLE.
  - DIFF, CNT, HOLD_CNT, TRIG, TRIG_PATTERN and TRIG_COUNT all become 0.

## Timing
- Latency: first over-threshold sample captured on edge k → TRIG high after edge k+MIN_WIDTH+1 (MIN_WIDTH≥1). For MIN_WIDTH=1, TRIG rises on edge k+2.
- Dead time after a trigger edge: HOLDOFF+1 cycles in HOLDOFF, plus REARM cycles until HIT falls, plus 1 cycle in IDLE before the next trigger can be decided. Minimum trigger-to-trigger spacing is HOLDOFF+3 edges.
- A HIT coinciding with the REARM→IDLE transition does not trigger; detection starts from IDLE.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Package mt_pkg:
  - State enum {IDLE, HOLDOFF, REARM}.
  - ADC_WIDTH=24, HG_MSB=23, HG_LSB=12, SAMPLE_WIDTH=12, NCHAN=3.
- Sub-module trig_chan_qual, instantiated 3×:
  - Contains pedestal subtract, threshold compare and saturating width counter.
  - Outputs QUAL.
- Top-level contains popcount, FSM, holdoff counter and trigger counter.

## Test plan
- Single pulse on ADC0 only:
  - Stimulus: PED=200, THR=100, MULT=1, MINW=1. HG=200 baseline, HG=350 for 5 samples.
  - Response: one TRIG 2 edges after the first 350 sample, TRIG_PATTERN=3'b001, TRIG_COUNT=1.
- Coincidence: MULT=2, HG=350 on ADC0 only → no TRIG. Same pulse on ADC0 and ADC2 with a 1-cycle offset → TRIG with pattern 3'b101, on the edge after the second channel qualifies.
- Width and saturation:
  - MINW=3 with a 2-sample pulse → no TRIG; a 3-sample pulse → TRIG.
  - HG=100 with PED=200 → DIFF=0, no underflow trigger.
- Holdoff/rearm:
  - HOLDOFF=10, two pulses 8 cycles apart → one TRIG.
  - Pulses 20 cycles apart → two TRIGs, TRIG_COUNT=2.
  - A continuous HG=350 for 100 cycles → exactly one TRIG.
- Control and reset:
  - ENABLE=0 during a pulse → no TRIG and count unchanged.
  - CLR_COUNT coincident with a trigger → TRIG_COUNT=0.
  - RST asserted in HOLDOFF → all outputs 0, next pulse triggers normally.
  - MULT=0 → never triggers.
